xor_stream_decoder: RTL and testbench

//  Decode side of the pipeline's XOR word cipher: cipher = plain ^ key, where key
//  is a 32-bit Galois LFSR keystream seeded per frame. Regenerates the same keystream,

---
 rtl/xor_dec_pkg.sv | 12 +
 rtl/xor_lfsr_keygen.sv | 20 ++
 rtl/xor_stream_decoder.sv | 105 ++++++++++
 tb/tb_xor_stream_decoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/xor_dec_pkg.sv
// xor_dec_pkg: shared types and constants for the XOR stream decoder.
// Provides the FSM state enum, the default Galois tap mask, the zero-seed
// substitute and the single-step LFSR helper used by the keystream generator.
package xor_dec_pkg;
  localparam int KEY_W = 32;
  localparam logic [KEY_W-1:0] DEFAULT_LFSR_POLY = 32'h80200003;
  localparam logic [KEY_W-1:0] SEED_ZERO_SUB = 32'h1;
  typedef enum logic [1:0] {IDLE, DATA, CHECK, FIN} stateT;
  function automatic logic [KEY_W-1:0] lfsr_next(input logic [KEY_W-1:0] poly, input logic [KEY_W-1:0] val);
    return (val >> 1) ^ (val[0] ? poly : '0);
  endfunction
endpackage

// File: rtl/xor_lfsr_keygen.sv
// xor_lfsr_keygen: Galois LFSR keystream register.
// Ports: clock/reset_n (async active-low), load + seed (zero seed becomes 1),
// advance (step once per consumed word), key (current keystream word).
module xor_lfsr_keygen
  import xor_dec_pkg::*;
#(
  parameter logic [KEY_W-1:0] POLY = DEFAULT_LFSR_POLY
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [KEY_W-1:0] seed,
  input  logic             advance,
  output logic [KEY_W-1:0] key
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) key <= SEED_ZERO_SUB;
    else if (load) key <= (seed == '0) ? SEED_ZERO_SUB : seed;
    else if (advance) key <= lfsr_next(POLY, key);
endmodule

// File: rtl/xor_stream_decoder.sv
// xor_stream_decoder: length-framed XOR keystream decoder with valid/ready on both sides.
// Ports: clock, reset_n (async active-low); start/seed/len open a frame from IDLE;
// in_valid/in_ready/in_data encoded input; out_valid/out_ready/out_data/out_last
// decoded output; busy (not IDLE), done (completion pulse), err (trailer mismatch).
// Build option XOR_DEC_CHECK_EN: adds the CHECK state that consumes and compares a
// trailer word (XOR of all plaintext words); without it err is tied low.
module xor_stream_decoder
  import xor_dec_pkg::*;
#(
  parameter int                DATA_W    = KEY_W,
  parameter int                LEN_W     = 8,
  parameter logic [DATA_W-1:0] LFSR_POLY = DEFAULT_LFSR_POLY
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
`ifdef XOR_DEC_CHECK_EN
  localparam stateT AFTER_DATA = CHECK;
`else
  localparam stateT AFTER_DATA = FIN;
`endif
  stateT state, stateNext;
  logic [LEN_W-1:0] cnt;
  logic [DATA_W-1:0] key, plain;
  logic startAcc, fire, dataFire, lastFire, drainOk;
  assign startAcc = state == IDLE && start;
  assign fire = in_valid && in_ready;
  assign dataFire = fire && state == DATA;
  assign lastFire = dataFire && cnt == LEN_W'(1);
  // FIN may only finish once the output register is empty or emptying this cycle,
  // so done never appears while a decoded word is still being held.
  assign drainOk = !out_valid || out_ready;
  assign plain = in_data ^ key;
  xor_lfsr_keygen #(.POLY(LFSR_POLY)) keygen (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (startAcc),
    .seed   (seed),
    .advance(dataFire),
    .key    (key)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = (len != '0) ? DATA : AFTER_DATA;
      DATA:    if (lastFire) stateNext = AFTER_DATA;
      CHECK:   if (fire) stateNext = FIN;
      FIN:     if (drainOk) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == DATA ? drainOk : state == CHECK;
    busy = state != IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      done <= state == FIN && drainOk;
      if (startAcc) cnt <= len;
      else if (dataFire) cnt <= cnt - LEN_W'(1);
      if (dataFire) begin
        out_valid <= 1'b1;
        out_data <= plain;
        out_last <= lastFire;
      end else if (out_ready) out_valid <= 1'b0;
    end
`ifdef XOR_DEC_CHECK_EN
  logic [DATA_W-1:0] csum;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      csum <= '0;
      err <= 1'b0;
    end else if (startAcc) begin
      csum <= '0;
      err <= 1'b0;
    end else begin
      if (dataFire) csum <= csum ^ plain;
      if (fire && state == CHECK) err <= in_data != csum;
    end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_xor_stream_decoder.sv
// tb_xor_stream_decoder: directed table-driven bench for xor_stream_decoder.
module tb_xor_stream_decoder;
`ifdef XOR_DEC_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] seed = '0, in_data = '0;
  logic [7:0] len = '0;
  logic in_ready, out_valid, out_last, busy, done, err;
  logic [31:0] out_data;
  int checks = 0, errors = 0;

  typedef struct {
    logic st; logic [31:0] sd; logic [7:0] ln; logic iv; logic [31:0] id; logic ordy;
    logic ov; logic [31:0] od; logic ol; logic ir; logic bz; logic dn; logic er;
  } vecT;
  vecT vec[$];

  xor_stream_decoder dut (
    .clock(clock), .reset_n(reset_n), .start(start), .seed(seed), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vecT mk(logic st, logic [31:0] sd, logic [7:0] ln, logic iv, logic [31:0] id,
                             logic ordy, logic ov, logic [31:0] od, logic ol, logic ir, logic bz,
                             logic dn, logic er);
    vecT v;
    v = '{st, sd, ln, iv, id, ordy, ov, od, ol, ir, bz, dn, er};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [31:0] sd, input logic [7:0] ln,
                       input logic iv, input logic [31:0] id, input logic ordy);
    @(negedge clock);
    start = st; seed = sd; len = ln; in_valid = iv; in_data = id; out_ready = ordy;
    @(posedge clock);
    #1;
  endtask

  task automatic waitDone(input string nm);
    for (int i = 0; i < 8 && !done; i++) drive(0, 0, 0, 0, 0, 1);
    chk({nm, " done"}, done, 1);
    drive(0, 0, 0, 0, 0, 1);
    chk({nm, " done pulse"}, done, 0);
  endtask

  initial begin
    // test 1: seed 1, len 2, zero words -> keys 0x1, 0x80200003
    vec.push_back(mk(1, 1, 2, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    vec.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'h1, 0, 1, 1, 0, 0));
    vec.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'h80200003, 1, EN, 1, 0, 0));
    if (EN) vec.push_back(mk(0, 0, 0, 1, 32'h80200002, 1, 0, 0, 0, 0, 1, 0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // test 3: empty frame
    vec.push_back(mk(1, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, EN, 1, 0, 0));
    if (EN) vec.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // test 4: bad trailer, err sticky until next start
    vec.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    vec.push_back(mk(0, 0, 0, 1, 32'h12345678, 1, 1, 32'h12345679, 1, EN, 1, 0, 0));
    if (EN) vec.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1));
    vec.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, EN));
    vec.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, EN));
    vec.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, EN));
    // test 5: zero seed substitution; start clears err
    vec.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    vec.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'h1, 1, EN, 1, 0, 0));
    if (EN) vec.push_back(mk(0, 0, 0, 1, 32'h1, 1, 0, 0, 0, 0, 1, 0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));

    repeat (2) @(negedge clock);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_last", out_last, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    reset_n = 1'b1;

    foreach (vec[i]) begin
      drive(vec[i].st, vec[i].sd, vec[i].ln, vec[i].iv, vec[i].id, vec[i].ordy);
      chk($sformatf("v%0d out_valid", i), out_valid, vec[i].ov);
      chk($sformatf("v%0d in_ready", i), in_ready, vec[i].ir);
      chk($sformatf("v%0d busy", i), busy, vec[i].bz);
      chk($sformatf("v%0d done", i), done, vec[i].dn);
      chk($sformatf("v%0d err", i), err, vec[i].er);
      if (vec[i].ov) begin
        chk($sformatf("v%0d out_data", i), out_data, vec[i].od);
        chk($sformatf("v%0d out_last", i), out_last, vec[i].ol);
      end
    end

    // test 2: backpressure holds the first word, then the second follows intact
    drive(1, 1, 2, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    chk("bp w0 data", out_data, 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      chk($sformatf("bp hold%0d valid", i), out_valid, 1);
      chk($sformatf("bp hold%0d data", i), out_data, 32'h1);
      chk($sformatf("bp hold%0d last", i), out_last, 0);
      chk($sformatf("bp hold%0d in_ready", i), in_ready, 0);
      chk($sformatf("bp hold%0d done", i), done, 0);
    end
    drive(0, 0, 0, 1, 0, 1);
    chk("bp w1 valid", out_valid, 1);
    chk("bp w1 data", out_data, 32'h80200003);
    chk("bp w1 last", out_last, 1);
    if (EN) begin
      drive(0, 0, 0, 1, 32'h80200002, 1);
      chk("bp trailer err", err, 0);
    end
    waitDone("bp");

    // test 6: asynchronous reset mid-frame, then a clean frame
    drive(1, 1, 3, 0, 0, 1);
    drive(0, 0, 0, 1, 32'hFFFF0000, 1);
    chk("ar pre valid", out_valid, 1);
    #2 reset_n = 1'b0;
    start = 0; in_valid = 0;
    #1;
    chk("ar out_valid", out_valid, 0);
    chk("ar out_data", out_data, 0);
    chk("ar busy", busy, 0);
    chk("ar in_ready", in_ready, 0);
    chk("ar done", done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk($sformatf("ar idle%0d done", i), done, 0);
      chk($sformatf("ar idle%0d busy", i), busy, 0);
    end
    drive(1, 1, 2, 0, 0, 1);
    drive(0, 0, 0, 1, 32'hA5A5A5A5, 1);
    chk("ar w0 data", out_data, 32'hA5A5A5A4);
    drive(0, 0, 0, 1, 0, 1);
    chk("ar w1 data", out_data, 32'h80200003);
    chk("ar w1 last", out_last, 1);
    if (EN) begin
      drive(0, 0, 0, 1, 32'h2585A5A7, 1);
      chk("ar trailer err", err, 0);
    end
    waitDone("ar");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
